tmeasure_sequencer: RTL



---
 rtl/tmeasure_pkg.sv | 30 +++
 rtl/tmeasure_sequencer_if.sv | 39 +++
 rtl/tmeasure_timeout.sv | 37 +++
 rtl/tmeasure_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tmeasure_pkg.sv
// Shared types and helpers for the period-measurement sequencer:
// one-hot state encoding, result codes and the range qualification rule.
package tmeasure_pkg;

    localparam int N_RANGES_DEFAULT = 5;

    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_START     = 6'b000010,
        ST_WAIT_BUSY = 6'b000100,
        ST_WAIT_DONE = 6'b001000,
        ST_SCAN      = 6'b010000,
        ST_PRESENT   = 6'b100000
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_NO_RANGE = 2'd1,
        ERR_START_TO = 2'd2,
        ERR_DONE_TO  = 2'd3
    } res_err_t;

    // A count is usable when it is strictly positive and not above the
    // accepted maximum; negative values flag a broken range.
    function automatic logic range_ok(input logic signed [31:0] v,
                                      input logic signed [31:0] max_count);
        return (v > 32'sd0) && (v <= max_count);
    endfunction

endpackage

// File: rtl/tmeasure_sequencer_if.sv
// Measurement-side and result-side signals of the sequencer.
// master = the sequencer, slave = measurement top plus result consumer.
interface tmeasure_sequencer_if #(
    parameter int N_RANGES = tmeasure_pkg::N_RANGES_DEFAULT
);
    import tmeasure_pkg::*;

    logic               meas_start;
    logic               meas_busy;
    logic signed [31:0] meas_val [N_RANGES];
    logic               res_valid;
    logic               res_ready;
    logic [2:0]         res_range;
    logic [31:0]        res_count;
    res_err_t           res_err;

    modport master (
        output meas_start,
        input  meas_busy,
        input  meas_val,
        output res_valid,
        input  res_ready,
        output res_range,
        output res_count,
        output res_err
    );

    modport slave (
        input  meas_start,
        output meas_busy,
        output meas_val,
        input  res_valid,
        output res_ready,
        input  res_range,
        input  res_count,
        input  res_err
    );

endinterface

// File: rtl/tmeasure_timeout.sv
// Loadable saturating cycle counter. Loading sets the limit and restarts
// the count; tc is high during the cycle that completes the limit-th
// counted cycle, so a state that waits on tc lasts exactly 'limit' cycles.
module tmeasure_timeout #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clr,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count_reg;
    logic [W-1:0] limit_reg;

    // Count enabled cycles, stopping at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            limit_reg <= '0;
        end else if (load) begin
            limit_reg <= load_val;
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // One extra bit keeps the +1 from wrapping at saturation.
    assign tc = (({1'b0, count_reg} + {{W{1'b0}}, 1'b1}) >= {1'b0, limit_reg});

endmodule

// File: rtl/tmeasure_sequencer.sv
// Sequencer for the multi-range period measurement: starts a measurement,
// waits out the busy window, captures all range counts and presents the
// finest-resolution valid count on a valid/ready result port.
module tmeasure_sequencer
    import tmeasure_pkg::*;
#(
    parameter int          N_RANGES      = N_RANGES_DEFAULT,
    parameter logic [31:0] MAX_COUNT     = 32'd100_000_000,
    parameter int          START_TIMEOUT = 4,
    parameter int          DONE_TIMEOUT  = 2**24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    output logic                  idle,
    tmeasure_sequencer_if.master  bus
);

    localparam int TW = $clog2(DONE_TIMEOUT) + 1;

    state_t             state_reg, state_next;
    logic signed [31:0] cap_reg [N_RANGES];
    logic [2:0]         scan_idx_reg, scan_idx_next;
    logic [2:0]         res_range_reg, res_range_next;
    logic [31:0]        res_count_reg, res_count_next;
    res_err_t           res_err_reg, res_err_next;
    logic               meas_start_reg;
    logic               res_valid_reg;
    logic               idle_reg;

    logic               capture;
    logic               tmr_load;
    logic [TW-1:0]      tmr_load_val;
    logic               tmr_clr;
    logic               tmr_en;
    logic               tmr_tc;

    tmeasure_timeout #(.W(TW)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );

    // State, scan pointer and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            scan_idx_reg  <= '0;
            res_range_reg <= '0;
            res_count_reg <= '0;
            res_err_reg   <= ERR_OK;
        end else begin
            state_reg     <= state_next;
            scan_idx_reg  <= scan_idx_next;
            res_range_reg <= res_range_next;
            res_count_reg <= res_count_next;
            res_err_reg   <= res_err_next;
        end
    end

    // Output flags are computed from the next state so they are registered
    // yet line up with the state they describe. meas_start covers START and
    // the first WAIT_BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas_start_reg <= 1'b0;
            res_valid_reg  <= 1'b0;
            idle_reg       <= 1'b1;
        end else begin
            meas_start_reg <= (state_next == ST_START) || (state_reg == ST_START);
            res_valid_reg  <= (state_next == ST_PRESENT);
            idle_reg       <= (state_next == ST_IDLE);
        end
    end

    // Snapshot every range on the edge where busy is first seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_RANGES; i++) cap_reg[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < N_RANGES; i++) cap_reg[i] <= bus.meas_val[i];
        end
    end

    // Next-state, timer control and result selection.
    always_comb begin
        state_next     = state_reg;
        scan_idx_next  = scan_idx_reg;
        res_range_next = res_range_reg;
        res_count_next = res_count_reg;
        res_err_next   = res_err_reg;
        capture        = 1'b0;
        tmr_load       = 1'b0;
        tmr_load_val   = '0;
        tmr_clr        = 1'b0;
        tmr_en         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (req) state_next = ST_START;
            end
            ST_START: begin
                tmr_load     = 1'b1;
                tmr_load_val = TW'(START_TIMEOUT);
                state_next   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                tmr_en = 1'b1;
                // Busy is checked first so it wins over a same-cycle timeout.
                if (bus.meas_busy) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(DONE_TIMEOUT);
                    state_next   = ST_WAIT_DONE;
                end else if (tmr_tc) begin
                    res_range_next = '0;
                    res_count_next = '0;
                    res_err_next   = ERR_START_TO;
                    state_next     = ST_PRESENT;
                end
            end
            ST_WAIT_DONE: begin
                tmr_en = 1'b1;
                if (!bus.meas_busy) begin
                    capture       = 1'b1;
                    scan_idx_next = '0;
                    state_next    = ST_SCAN;
                end else if (tmr_tc) begin
                    res_range_next = '0;
                    res_count_next = '0;
                    res_err_next   = ERR_DONE_TO;
                    state_next     = ST_PRESENT;
                end
            end
            ST_SCAN: begin
                if (range_ok(cap_reg[scan_idx_reg], $signed(MAX_COUNT))) begin
                    res_range_next = scan_idx_reg;
                    res_count_next = cap_reg[scan_idx_reg];
                    res_err_next   = ERR_OK;
                    state_next     = ST_PRESENT;
                end else if (scan_idx_reg == 3'(N_RANGES - 1)) begin
                    res_range_next = '0;
                    res_count_next = '0;
                    res_err_next   = ERR_NO_RANGE;
                    state_next     = ST_PRESENT;
                end else begin
                    scan_idx_next = scan_idx_reg + 3'd1;
                end
            end
            ST_PRESENT: begin
                if (bus.res_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.meas_start = meas_start_reg;
    assign bus.res_valid  = res_valid_reg;
    assign bus.res_range  = res_range_reg;
    assign bus.res_count  = res_count_reg;
    assign bus.res_err    = res_err_reg;
    assign idle           = idle_reg;

endmodule
